// File: rtl/encoder_ctrl_pkg.sv
// Shared types and widths for the encoder frame scheduler and its latent FIFO.
package encoder_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT
   } sched_state_t;

   localparam int FRAME_CNT_W = 16;

   // Watchdog counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
   function automatic int timer_width(input int timeout);
      return $clog2(timeout);
   endfunction

endpackage

// File: rtl/latent_fifo.sv
// Circular-buffer FIFO holding completed latent vectors until the consumer takes them.
module latent_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   // The scheduler reserves a slot before launching, so a push never meets a full FIFO.
   assign push_ok = push && (count_q != CNT_W'(DEPTH));
   assign pop_ok  = pop && (count_q != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
         unique case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/encoder_frame_scheduler.sv
// Sequences one frame at a time through the encoder: latch, start pulse, watchdogged wait,
// then queue the latent vector for the downstream consumer.
module encoder_frame_scheduler
   import encoder_ctrl_pkg::*;
#(
   parameter int IN_WIDTH     = 12,
   parameter int INPUT_NUM    = 400,
   parameter int OUTPUT_WIDTH = 8,
   parameter int OUT_NUM      = 16,
   parameter int FIFO_DEPTH   = 2,
   parameter int TIMEOUT      = 1024
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   input  logic [IN_WIDTH*INPUT_NUM-1:0]         s_data,
   output logic                                  enc_valid,
   output logic [IN_WIDTH*INPUT_NUM-1:0]         enc_x,
   input  logic signed [OUTPUT_WIDTH-1:0]        enc_out [OUT_NUM],
   input  logic                                  enc_out_ready,
   output logic                                  m_valid,
   input  logic                                  m_ready,
   output logic [OUTPUT_WIDTH*OUT_NUM-1:0]       m_data,
   output logic                                  busy,
   output logic                                  timeout_err,
   output logic [FRAME_CNT_W-1:0]                frame_count
);

   localparam int FRAME_W = IN_WIDTH*INPUT_NUM;
   localparam int LAT_W   = OUTPUT_WIDTH*OUT_NUM;
   localparam int TIMER_W = timer_width(TIMEOUT);
   localparam int CNT_W   = $clog2(FIFO_DEPTH+1);

   sched_state_t            state_q, state_d;
   logic [FRAME_W-1:0]      enc_x_q;
   logic [TIMER_W-1:0]      timer_q, timer_d;
   logic                    timeout_err_q, timeout_err_d;
   logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [LAT_W-1:0]        enc_flat;
   logic [CNT_W-1:0]        fifo_count;
   logic                    push;
   logic                    accept;

   always_comb begin
      enc_flat = '0;
      for (int j = 0; j < OUT_NUM; j++) enc_flat[j*OUTPUT_WIDTH +: OUTPUT_WIDTH] = enc_out[j];
   end

   assign s_ready = (state_q == IDLE) && (fifo_count < CNT_W'(FIFO_DEPTH));
   assign accept  = s_valid && s_ready;

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      timeout_err_d = timeout_err_q;
      frame_cnt_d   = frame_cnt_q;
      push          = 1'b0;
      enc_valid     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = LAUNCH;
         end
         LAUNCH: begin
            enc_valid = 1'b1;
            timer_d   = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            timer_d = timer_q + 1'b1;
            // A result on the last watchdog cycle still counts as success.
            if (enc_out_ready) begin
               push        = 1'b1;
               frame_cnt_d = frame_cnt_q + 1'b1;
               state_d     = IDLE;
            end else if (timer_q == TIMER_W'(TIMEOUT-1)) begin
               timeout_err_d = 1'b1;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         enc_x_q       <= '0;
         timer_q       <= '0;
         timeout_err_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         timeout_err_q <= timeout_err_d;
         frame_cnt_q   <= frame_cnt_d;
         if (accept) enc_x_q <= s_data;
      end
   end

   latent_fifo #(
      .WIDTH (LAT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (m_valid && m_ready),
      .wdata (enc_flat),
      .rdata (m_data),
      .count (fifo_count)
   );

   assign m_valid     = (fifo_count != '0);
   assign enc_x       = enc_x_q;
   assign busy        = (state_q != IDLE);
   assign timeout_err = timeout_err_q;
   assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_encoder_frame_scheduler.sv
// Directed bench for encoder_frame_scheduler with a small frame/latent geometry and a 16-cycle watchdog.
module tb_encoder_frame_scheduler;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                s_valid = 1'b0;
   logic                s_ready;
   logic [47:0]         s_data = '0;
   logic                enc_valid;
   logic [47:0]         enc_x;
   logic signed [7:0]   enc_out [4];
   logic                enc_out_ready = 1'b0;
   logic                m_valid;
   logic                m_ready = 1'b0;
   logic [31:0]         m_data;
   logic                busy;
   logic                timeout_err;
   logic [15:0]         frame_count;

   int n_vec = 0;
   int n_bad = 0;

   encoder_frame_scheduler #(
      .IN_WIDTH     (12),
      .INPUT_NUM    (4),
      .OUTPUT_WIDTH (8),
      .OUT_NUM      (4),
      .FIFO_DEPTH   (2),
      .TIMEOUT      (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .enc_valid     (enc_valid),
      .enc_x         (enc_x),
      .enc_out       (enc_out),
      .enc_out_ready (enc_out_ready),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .busy          (busy),
      .timeout_err   (timeout_err),
      .frame_count   (frame_count)
   );

   always #5 clk = ~clk;

   task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_lat(input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
      enc_out[0] = e0;
      enc_out[1] = e1;
      enc_out[2] = e2;
      enc_out[3] = e3;
   endtask

   // Offer a frame while IDLE; returns in the first WAIT cycle.
   task automatic launch(input logic [47:0] frame);
      s_valid = 1'b1;
      s_data  = frame;
      #1;
      expect_eq("accept_ready", s_ready, 1'b1);
      step();
      s_valid = 1'b0;
      s_data  = 48'hFFF_FFF_FFF_FFF;
      #1;
      expect_eq("launch_pulse", enc_valid, 1'b1);
      expect_eq("launch_x", enc_x, frame);
      expect_eq("launch_sready", s_ready, 1'b0);
      step();
      #1;
      expect_eq("wait_pulse_low", enc_valid, 1'b0);
      expect_eq("wait_busy", busy, 1'b1);
      expect_eq("wait_x_hold", enc_x, frame);
   endtask

   // Encoder answers k cycles after WAIT entry; returns in cycle W+1.
   task automatic respond(input int k, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
      repeat (k) step();
      enc_out_ready = 1'b1;
      set_lat(e0, e1, e2, e3);
      step();
      enc_out_ready = 1'b0;
      #1;
   endtask

   initial begin
      set_lat(8'h00, 8'h00, 8'h00, 8'h00);
      #13;
      expect_eq("rst_m_valid", m_valid, 1'b0);
      expect_eq("rst_m_data", m_data, 32'h0);
      expect_eq("rst_busy", busy, 1'b0);
      expect_eq("rst_timeout", timeout_err, 1'b0);
      expect_eq("rst_fcount", frame_count, 16'd0);
      expect_eq("rst_enc_valid", enc_valid, 1'b0);
      expect_eq("rst_enc_x", enc_x, 48'h0);
      step();
      rst = 1'b0;
      #1;
      expect_eq("rst_s_ready", s_ready, 1'b1);

      // single frame, encoder latency of 10 WAIT cycles, consumer always ready
      m_ready = 1'b1;
      launch(48'h123_456_789_ABC);
      respond(10, 8'h11, 8'h22, 8'h33, 8'h44);
      expect_eq("single_m_valid", m_valid, 1'b1);
      expect_eq("single_m_data", m_data, 32'h44332211);
      expect_eq("single_fcount", frame_count, 16'd1);
      expect_eq("single_idle", busy, 1'b0);
      expect_eq("single_s_ready", s_ready, 1'b1);
      step();
      #1;
      expect_eq("single_drained", m_valid, 1'b0);

      // push and pop in the same cycle with one entry queued
      m_ready = 1'b0;
      launch(48'hAAA_BBB_CCC_DDD);
      respond(3, 8'h80, 8'h7F, 8'h01, 8'hFF);
      expect_eq("pp_first_data", m_data, 32'hFF017F80);
      launch(48'h001_002_003_004);
      repeat (3) step();
      enc_out_ready = 1'b1;
      m_ready = 1'b1;
      set_lat(8'hF0, 8'h0E, 8'hA5, 8'h5A);
      step();
      enc_out_ready = 1'b0;
      #1;
      expect_eq("pp_m_valid", m_valid, 1'b1);
      expect_eq("pp_m_data", m_data, 32'h5AA50EF0);
      expect_eq("pp_s_ready", s_ready, 1'b1);
      expect_eq("pp_fcount", frame_count, 16'd3);
      step();
      #1;
      expect_eq("pp_count_one", m_valid, 1'b0);
      m_ready = 1'b0;

      // back-pressure: two frames fill the FIFO, the third must wait
      launch(48'h111_111_111_111);
      respond(2, 8'h01, 8'h02, 8'h03, 8'h04);
      launch(48'h222_222_222_222);
      respond(2, 8'h10, 8'h20, 8'h30, 8'h40);
      s_valid = 1'b1;
      s_data  = 48'h333_333_333_333;
      #1;
      expect_eq("bp_full_ready", s_ready, 1'b0);
      repeat (5) step();
      #1;
      expect_eq("bp_still_blocked", s_ready, 1'b0);
      expect_eq("bp_no_launch", busy, 1'b0);
      expect_eq("bp_enc_x_hold", enc_x, 48'h222_222_222_222);
      expect_eq("bp_fcount", frame_count, 16'd5);
      expect_eq("bp_head", m_data, 32'h04030201);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      #1;
      expect_eq("bp_slot_freed", s_ready, 1'b1);
      expect_eq("bp_next_head", m_data, 32'h40302010);
      step();
      s_valid = 1'b0;
      #1;
      expect_eq("bp_relaunch", enc_valid, 1'b1);
      expect_eq("bp_relaunch_x", enc_x, 48'h333_333_333_333);
      step();
      respond(1, 8'h55, 8'h66, 8'h77, 8'h88);
      expect_eq("bp_third_done", frame_count, 16'd6);
      m_ready = 1'b1;
      #1;
      expect_eq("bp_drain0", m_data, 32'h40302010);
      step();
      #1;
      expect_eq("bp_drain1", m_data, 32'h88776655);
      step();
      #1;
      expect_eq("bp_empty", m_valid, 1'b0);

      // result arrives on the last watchdog cycle
      launch(48'hABC_ABC_ABC_ABC);
      respond(15, 8'h7E, 8'h81, 8'hC3, 8'h3C);
      expect_eq("edge_no_timeout", timeout_err, 1'b0);
      expect_eq("edge_m_valid", m_valid, 1'b1);
      expect_eq("edge_m_data", m_data, 32'h3CC3817E);
      expect_eq("edge_fcount", frame_count, 16'd7);
      step();

      // watchdog: encoder never answers
      launch(48'hDEF_DEF_DEF_DEF);
      repeat (15) step();
      #1;
      expect_eq("wd_not_yet", timeout_err, 1'b0);
      expect_eq("wd_busy", busy, 1'b1);
      step();
      #1;
      expect_eq("wd_timeout", timeout_err, 1'b1);
      expect_eq("wd_idle", busy, 1'b0);
      expect_eq("wd_fifo_empty", m_valid, 1'b0);
      expect_eq("wd_fcount", frame_count, 16'd7);
      m_ready = 1'b0;
      enc_out_ready = 1'b1;
      set_lat(8'hEE, 8'hEE, 8'hEE, 8'hEE);
      repeat (2) step();
      enc_out_ready = 1'b0;
      #1;
      expect_eq("stale_no_push", m_valid, 1'b0);
      expect_eq("stale_fcount", frame_count, 16'd7);
      expect_eq("wd_sticky", timeout_err, 1'b1);

      // reset in the middle of WAIT with one vector queued
      launch(48'h010_020_030_040);
      respond(2, 8'h21, 8'h43, 8'h65, 8'h87);
      launch(48'h050_060_070_080);
      repeat (3) step();
      rst = 1'b1;
      #1;
      expect_eq("mrst_busy", busy, 1'b0);
      expect_eq("mrst_m_valid", m_valid, 1'b0);
      expect_eq("mrst_m_data", m_data, 32'h0);
      expect_eq("mrst_enc_x", enc_x, 48'h0);
      expect_eq("mrst_timeout", timeout_err, 1'b0);
      expect_eq("mrst_fcount", frame_count, 16'd0);
      expect_eq("mrst_enc_valid", enc_valid, 1'b0);
      step();
      rst = 1'b0;
      enc_out_ready = 1'b1;
      step();
      enc_out_ready = 1'b0;
      #1;
      expect_eq("mrst_stale", m_valid, 1'b0);
      expect_eq("mrst_stale_fc", frame_count, 16'd0);
      m_ready = 1'b1;
      launch(48'h0F0_0F0_0F0_0F0);
      respond(5, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
      expect_eq("post_m_valid", m_valid, 1'b1);
      expect_eq("post_m_data", m_data, 32'hDDCCBBAA);
      expect_eq("post_fcount", frame_count, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
